// File: rtl/bp_me_dma_multichannel_engine.sv
`default_nettype none
// ============================================================================
// Module   : bp_me_dma_multichannel_engine
// Brief    : Multi-channel 1-D strided copy DMA engine with a CSR window and a
//            single valid/ready memory port. Channels are served round-robin,
//            one element (read then write) per grant.
//            Optional feature macro: BP_DMA_IRQ_EN (per-channel irq enable and
//            done interrupt output).
// Revision : 1.0 - initial release
// ============================================================================
module bp_me_dma_multichannel_engine #(
    parameter int NUM_CH       = 4,
    parameter int ADDR_WIDTH   = 40,
    parameter int DATA_WIDTH   = 64,
    parameter int STRIDE_WIDTH = 32,
    parameter int COUNT_WIDTH  = 32,
    localparam int CH_ID_WIDTH = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     csr_w_v_i,
    input  logic                     csr_r_v_i,
    input  logic [CH_ID_WIDTH+2:0]   csr_addr_i,
    input  logic [DATA_WIDTH-1:0]    csr_data_i,
    output logic [DATA_WIDTH-1:0]    csr_data_o,
    output logic                     csr_data_v_o,
    output logic                     mem_req_v_o,
    input  logic                     mem_req_ready_and_i,
    output logic                     mem_req_w_o,
    output logic [ADDR_WIDTH-1:0]    mem_req_addr_o,
    output logic [DATA_WIDTH-1:0]    mem_req_data_o,
    input  logic                     mem_resp_v_i,
    input  logic [DATA_WIDTH-1:0]    mem_resp_data_i,
    output logic                     mem_resp_ready_and_o,
    output logic [NUM_CH-1:0]        busy_o,
    output logic                     irq_o
);

    // FSM encodings
    localparam logic [2:0] c_st_idle    = 3'd0;
    localparam logic [2:0] c_st_arb     = 3'd1;
    localparam logic [2:0] c_st_rd_req  = 3'd2;
    localparam logic [2:0] c_st_rd_wait = 3'd3;
    localparam logic [2:0] c_st_wr_req  = 3'd4;
    localparam logic [2:0] c_st_wr_wait = 3'd5;

    // CSR register offsets within a channel
    localparam logic [2:0] c_reg_rd_base   = 3'd0;
    localparam logic [2:0] c_reg_rd_stride = 3'd1;
    localparam logic [2:0] c_reg_wr_base   = 3'd2;
    localparam logic [2:0] c_reg_wr_stride = 3'd3;
    localparam logic [2:0] c_reg_count     = 3'd4;
    localparam logic [2:0] c_reg_ctrl      = 3'd5;
    localparam logic [2:0] c_reg_status    = 3'd6;

    // Per-channel configuration and progress
    logic [ADDR_WIDTH-1:0]   r_rd_base   [NUM_CH];
    logic [STRIDE_WIDTH-1:0] r_rd_stride [NUM_CH];
    logic [ADDR_WIDTH-1:0]   r_wr_base   [NUM_CH];
    logic [STRIDE_WIDTH-1:0] r_wr_stride [NUM_CH];
    logic [COUNT_WIDTH-1:0]  r_count     [NUM_CH];
    logic [ADDR_WIDTH-1:0]   r_rd_cur    [NUM_CH];
    logic [ADDR_WIDTH-1:0]   r_wr_cur    [NUM_CH];
    logic [COUNT_WIDTH-1:0]  r_remaining [NUM_CH];
    logic [NUM_CH-1:0]       r_busy;
    logic [NUM_CH-1:0]       r_done;
    logic [NUM_CH-1:0]       r_aborted;
    logic [NUM_CH-1:0]       r_abort_pend;
`ifdef BP_DMA_IRQ_EN
    logic [NUM_CH-1:0]       r_irq_en;
`endif

    // Engine state
    logic [2:0]              r_state;
    logic [2:0]              w_state_next;
    logic [CH_ID_WIDTH-1:0]  r_sel;
    logic [CH_ID_WIDTH-1:0]  r_rr_ptr;
    logic [DATA_WIDTH-1:0]   r_word;
    logic [DATA_WIDTH-1:0]   r_csr_data;
    logic                    r_csr_data_v;

    // Decoded CSR access and per-channel events
    logic [CH_ID_WIDTH-1:0]  w_csr_ch;
    logic [2:0]              w_csr_reg;
    logic                    w_ch_in_range;
    logic                    w_in_xfer;
    logic [NUM_CH-1:0]       w_wr_hit;
    logic [NUM_CH-1:0]       w_start;
    logic [NUM_CH-1:0]       w_abort;
    logic [NUM_CH-1:0]       w_active;
    logic [NUM_CH-1:0]       w_retire;
    logic [NUM_CH-1:0]       w_abort_now;
    logic [NUM_CH-1:0]       w_elig;
    logic                    w_grant_v;
    logic [CH_ID_WIDTH-1:0]  w_grant;
    logic [CH_ID_WIDTH-1:0]  w_grant_next;
    int                      w_idx;
    logic [DATA_WIDTH-1:0]   w_rd_data;
    logic                    w_unused_csr_bits;

    // Upper CSR write-data bits beyond the widest field are don't-care
    assign w_unused_csr_bits = ^csr_data_i;

    assign w_csr_ch      = csr_addr_i[CH_ID_WIDTH+2:3];
    assign w_csr_reg     = csr_addr_i[2:0];
    assign w_ch_in_range = (int'(w_csr_ch) < NUM_CH);
    assign w_in_xfer     = (r_state == c_st_rd_req) || (r_state == c_st_rd_wait) ||
                           (r_state == c_st_wr_req) || (r_state == c_st_wr_wait);

    function automatic logic [ADDR_WIDTH-1:0] sext_stride(input logic [STRIDE_WIDTH-1:0] s);
        return ADDR_WIDTH'($signed(s));
    endfunction

    // Per-channel CSR decode and element-retire events
    always_comb begin
        w_wr_hit    = '0;
        w_start     = '0;
        w_abort     = '0;
        w_active    = '0;
        w_retire    = '0;
        w_abort_now = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            w_wr_hit[c]    = csr_w_v_i && (int'(w_csr_ch) == c);
            w_start[c]     = w_wr_hit[c] && (w_csr_reg == c_reg_ctrl) && csr_data_i[0];
            w_abort[c]     = w_wr_hit[c] && (w_csr_reg == c_reg_ctrl) && csr_data_i[1] && r_busy[c];
            w_active[c]    = w_in_xfer && (int'(r_sel) == c);
            w_retire[c]    = w_active[c] && (r_state == c_st_wr_wait) && mem_resp_v_i;
            w_abort_now[c] = w_abort[c] && !w_active[c];
        end
        // A channel aborted in the arbitration cycle must not be granted
        w_elig = r_busy & ~w_abort_now;
    end

    // Round-robin grant: first eligible channel at or after the rr pointer
    always_comb begin
        w_grant_v    = 1'b0;
        w_grant      = '0;
        w_grant_next = '0;
        w_idx        = 0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            w_idx = int'(r_rr_ptr) + i;
            if (w_idx >= NUM_CH) begin
                w_idx = w_idx - NUM_CH;
            end
            if (w_elig[w_idx]) begin
                w_grant_v = 1'b1;
                w_grant   = CH_ID_WIDTH'(w_idx);
            end
        end
        w_grant_next = (int'(w_grant) == NUM_CH - 1) ? '0 : w_grant + 1'b1;
    end

    // FSM state register
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state logic, one transaction outstanding
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle:    if (|r_busy)             w_state_next = c_st_arb;
            c_st_arb:     w_state_next = w_grant_v ? c_st_rd_req : c_st_idle;
            c_st_rd_req:  if (mem_req_ready_and_i) w_state_next = c_st_rd_wait;
            c_st_rd_wait: if (mem_resp_v_i)        w_state_next = c_st_wr_req;
            c_st_wr_req:  if (mem_req_ready_and_i) w_state_next = c_st_wr_wait;
            c_st_wr_wait: if (mem_resp_v_i)        w_state_next = c_st_arb;
            default:      w_state_next = c_st_idle;
        endcase
    end

    // Memory port outputs derive from state and cursors, which are frozen
    // while a request is pending
    assign mem_req_v_o          = (r_state == c_st_rd_req) || (r_state == c_st_wr_req);
    assign mem_req_w_o          = (r_state == c_st_wr_req);
    assign mem_req_addr_o       = (r_state == c_st_rd_req) ? r_rd_cur[r_sel] :
                                  (r_state == c_st_wr_req) ? r_wr_cur[r_sel] : '0;
    assign mem_req_data_o       = (r_state == c_st_wr_req) ? r_word : '0;
    assign mem_resp_ready_and_o = (r_state == c_st_rd_wait) || (r_state == c_st_wr_wait);
    assign busy_o               = r_busy;
    assign csr_data_o           = r_csr_data;
    assign csr_data_v_o         = r_csr_data_v;

`ifdef BP_DMA_IRQ_EN
    assign irq_o = |(r_done & r_irq_en);
`else
    assign irq_o = 1'b0;
`endif

    // CSR read mux: live cursors/remaining while busy, programmed values otherwise
    always_comb begin
        w_rd_data = '0;
        if (w_ch_in_range) begin
            case (w_csr_reg)
                c_reg_rd_base:   w_rd_data = DATA_WIDTH'(r_busy[w_csr_ch] ? r_rd_cur[w_csr_ch]
                                                                        : r_rd_base[w_csr_ch]);
                c_reg_rd_stride: w_rd_data = DATA_WIDTH'(r_rd_stride[w_csr_ch]);
                c_reg_wr_base:   w_rd_data = DATA_WIDTH'(r_busy[w_csr_ch] ? r_wr_cur[w_csr_ch]
                                                                        : r_wr_base[w_csr_ch]);
                c_reg_wr_stride: w_rd_data = DATA_WIDTH'(r_wr_stride[w_csr_ch]);
                c_reg_count:     w_rd_data = DATA_WIDTH'(r_busy[w_csr_ch] ? r_remaining[w_csr_ch]
                                                                        : r_count[w_csr_ch]);
`ifdef BP_DMA_IRQ_EN
                c_reg_ctrl:      w_rd_data = DATA_WIDTH'({r_irq_en[w_csr_ch], 2'b00});
`endif
                c_reg_status:    w_rd_data = DATA_WIDTH'({r_aborted[w_csr_ch], r_done[w_csr_ch],
                                                          r_busy[w_csr_ch]});
                default:         w_rd_data = '0;
            endcase
        end
    end

    // Datapath: CSR side effects, arbitration bookkeeping, element retire
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int c = 0; c < NUM_CH; c++) begin
                r_rd_base[c]   <= '0;
                r_rd_stride[c] <= '0;
                r_wr_base[c]   <= '0;
                r_wr_stride[c] <= '0;
                r_count[c]     <= '0;
                r_rd_cur[c]    <= '0;
                r_wr_cur[c]    <= '0;
                r_remaining[c] <= '0;
            end
            r_busy       <= '0;
            r_done       <= '0;
            r_aborted    <= '0;
            r_abort_pend <= '0;
`ifdef BP_DMA_IRQ_EN
            r_irq_en     <= '0;
`endif
            r_sel        <= '0;
            r_rr_ptr     <= '0;
            r_word       <= '0;
            r_csr_data   <= '0;
            r_csr_data_v <= 1'b0;
        end else begin
            r_csr_data_v <= csr_r_v_i && !csr_w_v_i;
            r_csr_data   <= (csr_r_v_i && !csr_w_v_i) ? w_rd_data : '0;

            if ((r_state == c_st_rd_wait) && mem_resp_v_i) begin
                r_word <= mem_resp_data_i;
            end
            if ((r_state == c_st_arb) && w_grant_v) begin
                r_sel    <= w_grant;
                r_rr_ptr <= w_grant_next;
            end

            for (int c = 0; c < NUM_CH; c++) begin
                // Configuration is frozen while the channel is busy
                if (w_wr_hit[c] && !r_busy[c]) begin
                    case (w_csr_reg)
                        c_reg_rd_base:   r_rd_base[c]   <= csr_data_i[ADDR_WIDTH-1:0];
                        c_reg_rd_stride: r_rd_stride[c] <= csr_data_i[STRIDE_WIDTH-1:0];
                        c_reg_wr_base:   r_wr_base[c]   <= csr_data_i[ADDR_WIDTH-1:0];
                        c_reg_wr_stride: r_wr_stride[c] <= csr_data_i[STRIDE_WIDTH-1:0];
                        c_reg_count:     r_count[c]     <= csr_data_i[COUNT_WIDTH-1:0];
                        default: ;
                    endcase
                end
`ifdef BP_DMA_IRQ_EN
                if (w_wr_hit[c] && (w_csr_reg == c_reg_ctrl)) begin
                    r_irq_en[c] <= csr_data_i[2];
                end
`endif
                // Write-1-to-clear of done; a completion on the same edge wins
                if (w_wr_hit[c] && (w_csr_reg == c_reg_status) && csr_data_i[1]) begin
                    r_done[c] <= 1'b0;
                end

                if (w_retire[c]) begin
                    r_rd_cur[c]    <= r_rd_cur[c] + sext_stride(r_rd_stride[c]);
                    r_wr_cur[c]    <= r_wr_cur[c] + sext_stride(r_wr_stride[c]);
                    r_remaining[c] <= r_remaining[c] - 1'b1;
                    if (r_abort_pend[c] || w_abort[c]) begin
                        r_busy[c]       <= 1'b0;
                        r_aborted[c]    <= 1'b1;
                        r_done[c]       <= 1'b0;
                        r_abort_pend[c] <= 1'b0;
                    end else if (r_remaining[c] == COUNT_WIDTH'(1)) begin
                        r_busy[c] <= 1'b0;
                        r_done[c] <= 1'b1;
                    end
                end else if (w_abort[c]) begin
                    // An element in flight finishes before the channel stops
                    if (w_active[c]) begin
                        r_abort_pend[c] <= 1'b1;
                    end else begin
                        r_busy[c]    <= 1'b0;
                        r_aborted[c] <= 1'b1;
                        r_done[c]    <= 1'b0;
                    end
                end

                if (w_start[c] && !r_busy[c]) begin
                    r_rd_cur[c]     <= r_rd_base[c];
                    r_wr_cur[c]     <= r_wr_base[c];
                    r_remaining[c]  <= r_count[c];
                    r_aborted[c]    <= 1'b0;
                    r_abort_pend[c] <= 1'b0;
                    if (r_count[c] == '0) begin
                        r_busy[c] <= 1'b0;
                        r_done[c] <= 1'b1;
                    end else begin
                        r_busy[c] <= 1'b1;
                        r_done[c] <= 1'b0;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire
